// File: rtl/proc_mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the imem (port 0) and
// dmem (port 1) request streams; an order FIFO of grant ids steers each response home.
module proc_mem_port_arbiter #(
    parameter int p_req_nbits       = 77,
    parameter int p_resp_nbits      = 47,
    parameter int p_max_outstanding = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [p_req_nbits-1:0]               req0_msg,
    input  logic                                 req0_val,
    output logic                                 req0_rdy,

    input  logic [p_req_nbits-1:0]               req1_msg,
    input  logic                                 req1_val,
    output logic                                 req1_rdy,

    output logic [p_req_nbits-1:0]               mem_req_msg,
    output logic                                 mem_req_val,
    input  logic                                 mem_req_rdy,

    input  logic [p_resp_nbits-1:0]              mem_resp_msg,
    input  logic                                 mem_resp_val,
    output logic                                 mem_resp_rdy,

    output logic [p_resp_nbits-1:0]              resp0_msg,
    output logic                                 resp0_val,
    input  logic                                 resp0_rdy,

    output logic [p_resp_nbits-1:0]              resp1_msg,
    output logic                                 resp1_val,
    input  logic                                 resp1_rdy,

    output logic [$clog2(p_max_outstanding):0]   num_inflight,
    output logic                                 err_orphan
);

    localparam int ptr_nbits = $clog2(p_max_outstanding);
    localparam int cnt_nbits = ptr_nbits + 1;
    localparam logic [cnt_nbits-1:0] max_count = cnt_nbits'(p_max_outstanding);

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_id_e;

    port_id_e               pri;
    port_id_e               grant;
    port_id_e               head;
    port_id_e               id_fifo [p_max_outstanding];
    logic [ptr_nbits-1:0]   wr_ptr;
    logic [ptr_nbits-1:0]   rd_ptr;
    logic [cnt_nbits-1:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic can_issue;
    logic req_fire;
    logic resp_fire;
    logic orphan;

    assign fifo_full  = (count == max_count);
    assign fifo_empty = (count == '0);
    assign can_issue  = mem_req_rdy & ~fifo_full;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = PORT_IMEM;
        if (req0_val && req1_val) begin
            grant = pri;
        end else if (req1_val) begin
            grant = PORT_DMEM;
        end
    end

    assign mem_req_val = (req0_val | req1_val) & ~fifo_full;
    assign mem_req_msg = (grant == PORT_DMEM) ? req1_msg : req0_msg;
    assign req0_rdy    = can_issue & (grant == PORT_IMEM);
    assign req1_rdy    = can_issue & (grant == PORT_DMEM);
    assign req_fire    = mem_req_val & mem_req_rdy;

    // The head id is only meaningful while the FIFO holds entries; every use is gated by fifo_empty.
    assign head = id_fifo[rd_ptr];

    always_comb begin
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        mem_resp_rdy = 1'b1;
        if (!fifo_empty) begin
            if (head == PORT_DMEM) begin
                resp1_val    = mem_resp_val;
                mem_resp_rdy = resp1_rdy;
            end else begin
                resp0_val    = mem_resp_val;
                mem_resp_rdy = resp0_rdy;
            end
        end
    end

    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign resp_fire    = ~fifo_empty & mem_resp_val & mem_resp_rdy;
    assign orphan       = fifo_empty & mem_resp_val;
    assign num_inflight = count;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pri        <= PORT_IMEM;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (req_fire) begin
                wr_ptr <= wr_ptr + ptr_nbits'(1);
                pri    <= port_id_e'(~grant);
            end
            if (resp_fire) begin
                rd_ptr <= rd_ptr + ptr_nbits'(1);
            end
            case ({req_fire, resp_fire})
                2'b10:   count <= count + cnt_nbits'(1);
                2'b01:   count <= count - cnt_nbits'(1);
                default: count <= count;
            endcase
            if (orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // NOTE: the id storage has no reset; count and the pointers decide which entries are
    // live, so stale ids are never observed.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Directed bench for proc_mem_port_arbiter: request/response scoreboards filled as stimulus
// is queued, checked against a 1-cycle-latency memory model and per-port source models.
module tb_proc_mem_port_arbiter;

    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;
    localparam int MAXO   = 4;
    localparam int CNT_W  = $clog2(MAXO) + 1;

    typedef struct packed {
        logic              port;
        logic [RESP_W-1:0] msg;
    } exp_resp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ_W-1:0]  req0_msg = '0;
    logic              req0_val = 1'b0;
    logic              req0_rdy;
    logic [REQ_W-1:0]  req1_msg = '0;
    logic              req1_val = 1'b0;
    logic              req1_rdy;
    logic [REQ_W-1:0]  mem_req_msg;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [RESP_W-1:0] mem_resp_msg = '0;
    logic              mem_resp_val = 1'b0;
    logic              mem_resp_rdy;
    logic [RESP_W-1:0] resp0_msg;
    logic              resp0_val;
    logic              resp0_rdy;
    logic [RESP_W-1:0] resp1_msg;
    logic              resp1_val;
    logic              resp1_rdy;
    logic [CNT_W-1:0]  num_inflight;
    logic              err_orphan;

    proc_mem_port_arbiter #(
        .p_req_nbits      (REQ_W),
        .p_resp_nbits     (RESP_W),
        .p_max_outstanding(MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_msg     (req0_msg),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req1_msg     (req1_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .resp0_msg    (resp0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp1_msg    (resp1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .num_inflight (num_inflight),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [REQ_W-1:0]  src0_q[$];
    logic [REQ_W-1:0]  src1_q[$];
    logic [REQ_W-1:0]  exp_req[$];
    exp_resp_t         exp_resp[$];
    logic [RESP_W-1:0] mem_q[$];
    int                fire_log[$];
    int                fire_total = 0;
    int                cyc = 0;
    int                budget = -1;     // responses the memory may return; negative = unlimited
    logic              mem_manual = 1'b0;
    logic              manual_val = 1'b0;
    logic [RESP_W-1:0] manual_msg = '0;
    exp_resp_t         mon_e;
    logic [REQ_W-1:0]  mon_r;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_msg(input bit port, input int i);
        logic [31:0] addr;
        logic [31:0] data;
        addr = (port ? 32'h0000_2000 : 32'h0000_1000) + 32'(i * 4);
        data = port ? (32'hD000_0000 + 32'(i)) : 32'h0;
        return {3'(port), 8'(i), addr, 2'd0, data};
    endfunction

    function automatic logic [RESP_W-1:0] resp_of(input logic [REQ_W-1:0] m);
        return m[RESP_W-1:0] ^ 47'h1234_5678_9ABC;
    endfunction

    task automatic send(input bit port, input int i);
        logic [REQ_W-1:0] m;
        m = mk_msg(port, i);
        if (port) src1_q.push_back(m);
        else      src0_q.push_back(m);
        exp_req.push_back(m);
        exp_resp.push_back('{port: port, msg: resp_of(m)});
    endtask

    task automatic flush();
        src0_q.delete();
        src1_q.delete();
        exp_req.delete();
        exp_resp.delete();
        mem_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            done = (src0_q.size() == 0) && (src1_q.size() == 0) &&
                   (exp_req.size() == 0) && (exp_resp.size() == 0);
        end
        check({"idle_", tag}, 128'(done), 128'(1));
    endtask

    task automatic wait_fires(input string tag, input int target, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            done = (fire_total >= target);
        end
        check({"fires_", tag}, 128'(done), 128'(1));
    endtask

    // Sources, memory model and response monitor share one process so they sample the
    // same pre-edge values and update their drives together just after the edge.
    always @(posedge clk) begin
        if (reset) begin
            if (mem_req_val && mem_req_rdy) begin
                fire_total++;
                fire_log.push_back(cyc);
                check("req_expected", 128'(exp_req.size() != 0), 128'(1));
                if (exp_req.size() != 0) begin
                    mon_r = exp_req.pop_front();
                    check("req_msg", 128'(mem_req_msg), 128'(mon_r));
                end
                mem_q.push_back(resp_of(mem_req_msg));
            end
            if (!mem_manual && mem_resp_val && mem_resp_rdy && mem_q.size() != 0) begin
                void'(mem_q.pop_front());
                if (budget > 0) budget--;
            end
            if (resp0_val && resp0_rdy) begin
                check("resp0_expected", 128'(exp_resp.size() != 0), 128'(1));
                if (exp_resp.size() != 0) begin
                    mon_e = exp_resp.pop_front();
                    check("resp0_port", 128'(1'b0), 128'(mon_e.port));
                    check("resp0_msg", 128'(resp0_msg), 128'(mon_e.msg));
                end
            end
            if (resp1_val && resp1_rdy) begin
                check("resp1_expected", 128'(exp_resp.size() != 0), 128'(1));
                if (exp_resp.size() != 0) begin
                    mon_e = exp_resp.pop_front();
                    check("resp1_port", 128'(1'b1), 128'(mon_e.port));
                    check("resp1_msg", 128'(resp1_msg), 128'(mon_e.msg));
                end
            end
            if (req0_val && req0_rdy && src0_q.size() != 0) void'(src0_q.pop_front());
            if (req1_val && req1_rdy && src1_q.size() != 0) void'(src1_q.pop_front());
        end
        cyc++;
        #1;
        req0_val     = (src0_q.size() != 0);
        req0_msg     = (src0_q.size() != 0) ? src0_q[0] : '0;
        req1_val     = (src1_q.size() != 0);
        req1_msg     = (src1_q.size() != 0) ? src1_q[0] : '0;
        mem_resp_val = mem_manual ? manual_val : ((mem_q.size() != 0) && (budget != 0));
        mem_resp_msg = mem_manual ? manual_msg : ((mem_q.size() != 0) ? mem_q[0] : '0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset       = 1'b0;
        mem_req_rdy = 1'b1;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_inflight",  128'(num_inflight), 128'(0));
        check("rst_orphan",    128'(err_orphan),   128'(0));
        check("rst_mem_val",   128'(mem_req_val),  128'(0));
        check("rst_resp0_val", 128'(resp0_val),    128'(0));
        check("rst_resp1_val", 128'(resp1_val),    128'(0));
        check("rst_resp_rdy",  128'(mem_resp_rdy), 128'(1));
        reset = 1'b1;
        @(negedge clk);

        // Single-port streams, back to back
        fire_log.delete();
        for (int i = 0; i < 8; i++) send(1'b0, i);
        wait_idle("imem", 60);
        check("imem_fires", 128'(fire_log.size()), 128'(8));
        if (fire_log.size() == 8) check("imem_b2b", 128'(fire_log[7] - fire_log[0]), 128'(7));
        fire_log.delete();
        for (int i = 0; i < 8; i++) send(1'b1, 16 + i);
        wait_idle("dmem", 60);
        check("dmem_fires", 128'(fire_log.size()), 128'(8));
        if (fire_log.size() == 8) check("dmem_b2b", 128'(fire_log[7] - fire_log[0]), 128'(7));
        check("stream_orphan", 128'(err_orphan), 128'(0));

        // Both ports valid every cycle after a fresh reset: 0,1,0,1,...
        reset = 1'b0;
        flush();
        @(negedge clk);
        check("rst2_inflight", 128'(num_inflight), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        fire_log.delete();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32 + i);
            send(1'b1, 32 + i);
        end
        wait_idle("alt", 80);
        check("alt_fires", 128'(fire_log.size()), 128'(12));
        if (fire_log.size() == 12) check("alt_b2b", 128'(fire_log[11] - fire_log[0]), 128'(11));

        // Stalled responses fill the order FIFO
        budget = 0;
        @(negedge clk);
        base = fire_total;
        for (int i = 0; i < 4; i++) send(1'b0, 48 + i);
        wait_fires("fill", base + 4, 40);
        send(1'b1, 56);
        repeat (2) @(negedge clk);
        check("full_mem_val",  128'(mem_req_val),  128'(0));
        check("full_inflight", 128'(num_inflight), 128'(MAXO));
        check("full_req0_rdy", 128'(req0_rdy),     128'(0));
        check("full_req1_rdy", 128'(req1_rdy),     128'(0));
        budget = 1;
        @(negedge clk);
        check("pop_resp_val",  128'(mem_resp_val), 128'(1));
        check("pop_resp0_val", 128'(resp0_val),    128'(1));
        check("pop_mem_val",   128'(mem_req_val),  128'(0));
        check("pop_inflight",  128'(num_inflight), 128'(MAXO));
        @(negedge clk);
        check("after_pop_inflight", 128'(num_inflight), 128'(MAXO - 1));
        check("after_pop_mem_val",  128'(mem_req_val),  128'(1));
        check("after_pop_req1_rdy", 128'(req1_rdy),     128'(1));
        check("after_pop_msg",      128'(mem_req_msg),  128'(mk_msg(1'b1, 56)));
        @(negedge clk);
        check("refill_inflight", 128'(num_inflight), 128'(MAXO));
        budget = -1;
        wait_idle("drain", 60);

        // Interleaved 0,1,1,0 with dmem response backpressure
        resp1_rdy = 1'b0;
        base = fire_total;
        send(1'b0, 64);
        wait_fires("il_a", base + 1, 20);
        send(1'b1, 65);
        send(1'b1, 66);
        wait_fires("il_bc", base + 3, 20);
        send(1'b0, 67);
        wait_fires("il_d", base + 4, 20);
        @(negedge clk);
        check("blk_resp_val",  128'(mem_resp_val), 128'(1));
        check("blk_resp_rdy",  128'(mem_resp_rdy), 128'(0));
        check("blk_resp1_val", 128'(resp1_val),    128'(1));
        check("blk_resp0_val", 128'(resp0_val),    128'(0));
        check("blk_inflight",  128'(num_inflight), 128'(3));
        @(negedge clk);
        check("blk_hold_inflight", 128'(num_inflight), 128'(3));
        resp1_rdy = 1'b1;
        wait_idle("interleave", 40);

        // Orphan response while nothing is in flight
        manual_msg = 47'h1234_5678_9ABC;
        mem_manual = 1'b1;
        manual_val = 1'b1;
        @(negedge clk);
        check("orph_resp_rdy",  128'(mem_resp_rdy), 128'(1));
        check("orph_resp0_val", 128'(resp0_val),    128'(0));
        check("orph_resp1_val", 128'(resp1_val),    128'(0));
        check("orph_pre_flag",  128'(err_orphan),   128'(0));
        manual_val = 1'b0;
        @(negedge clk);
        check("orph_flag",     128'(err_orphan),   128'(1));
        check("orph_inflight", 128'(num_inflight), 128'(0));
        repeat (3) @(negedge clk);
        check("orph_sticky", 128'(err_orphan), 128'(1));
        mem_manual = 1'b0;

        // Asynchronous reset mid-burst, then resume
        budget = 0;
        @(negedge clk);
        base = fire_total;
        for (int i = 0; i < 3; i++) send(1'b0, 80 + i);
        wait_fires("burst", base + 3, 30);
        check("burst_inflight", 128'(num_inflight), 128'(3));
        #2;
        reset = 1'b0;
        flush();
        #1;
        check("async_inflight", 128'(num_inflight), 128'(0));
        check("async_orphan",   128'(err_orphan),   128'(0));
        check("async_resp_rdy", 128'(mem_resp_rdy), 128'(1));
        repeat (2) @(negedge clk);
        budget = -1;
        reset  = 1'b1;
        @(negedge clk);
        fire_log.delete();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 96 + i);
            send(1'b1, 96 + i);
        end
        wait_idle("resume", 60);
        check("resume_fires",    128'(fire_log.size()), 128'(6));
        check("resume_orphan",   128'(err_orphan),      128'(0));
        check("resume_inflight", 128'(num_inflight),    128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
